hazard_forward_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the 5-stage pipeline.
- Generates per-operand forwarding selects for the instruction in EX, with EX/MEM results taking priority over MEM/WB results.
- Detects load-use hazards against the instruction in ID and sequences a multi-cycle stall of LOAD_LAT cycles through a small FSM.
- Honours pipeline flush and memory-wait freeze.

---
 rtl/hazard_forward_unit_if.sv | 38 +++
 rtl/hazard_forward_unit.sv | 131 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the pipeline control path and hazard_forward_unit.
// STALL_CNT/FWD_CNT are always present; they read zero unless HAZARD_STATS_EN is defined.
interface hazard_forward_unit_if #(
  parameter int unsigned AW      = 5,
  parameter int unsigned NUM_SRC = 2
);
  logic [NUM_SRC*AW-1:0] ARS_EX;
  logic [NUM_SRC*AW-1:0] ARS_ID;
  logic [NUM_SRC-1:0]    SRC_VALID_ID;
  logic [AW-1:0]         ARD_ID_EX;
  logic                  MEMREAD_ID_EX;
  logic [AW-1:0]         ARD_EX_MEM;
  logic                  REGWRITE_EX_MEM;
  logic [AW-1:0]         ARD_MEM_WB;
  logic                  REGWRITE_MEM_WB;
  logic                  FLUSH;
  logic                  MEM_WAIT;
  logic [2*NUM_SRC-1:0]  FORWARD;
  logic                  STALL;
  logic                  BUBBLE;
  logic                  BUSY;
  logic [31:0]           STALL_CNT;
  logic [31:0]           FWD_CNT;

  modport master (
    output ARS_EX, ARS_ID, SRC_VALID_ID, ARD_ID_EX, MEMREAD_ID_EX,
           ARD_EX_MEM, REGWRITE_EX_MEM, ARD_MEM_WB, REGWRITE_MEM_WB,
           FLUSH, MEM_WAIT,
    input  FORWARD, STALL, BUBBLE, BUSY, STALL_CNT, FWD_CNT
  );

  modport slave (
    input  ARS_EX, ARS_ID, SRC_VALID_ID, ARD_ID_EX, MEMREAD_ID_EX,
           ARD_EX_MEM, REGWRITE_EX_MEM, ARD_MEM_WB, REGWRITE_MEM_WB,
           FLUSH, MEM_WAIT,
    output FORWARD, STALL, BUBBLE, BUSY, STALL_CNT, FWD_CNT
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects and load-use stall sequencing for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and forward-event counters.
module hazard_forward_unit #(
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1
) (
  input logic                  CLK,
  input logic                  RST,
  hazard_forward_unit_if.slave hif
);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t               state;
  logic [2:0]           cnt;
  logic [2*NUM_SRC-1:0] fwd;
  logic                 hit;
  logic                 stall;
  logic                 bubble;

  always_comb begin
    fwd = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (hif.REGWRITE_EX_MEM && hif.ARD_EX_MEM != '0 &&
          hif.ARD_EX_MEM == hif.ARS_EX[i*AW +: AW])
        fwd[2*i +: 2] = 2'b10;
      else if (hif.REGWRITE_MEM_WB && hif.ARD_MEM_WB != '0 &&
               hif.ARD_MEM_WB == hif.ARS_EX[i*AW +: AW])
        fwd[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (hif.SRC_VALID_ID[i] && hif.ARS_ID[i*AW +: AW] == hif.ARD_ID_EX)
        hit = 1'b1;
    end
    hit = hit && hif.MEMREAD_ID_EX && hif.ARD_ID_EX != '0;
  end

  // MEM_WAIT overrides FLUSH for STALL/BUBBLE; FLUSH still owns the FSM below.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (RST) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end else if (hif.MEM_WAIT) begin
      stall  = 1'b1;
    end else if (hif.FLUSH) begin
      stall  = 1'b0;
    end else if (state == S_STALL || hit) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (hif.FLUSH) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (!hif.MEM_WAIT) begin
      case (state)
        S_IDLE: begin
          if (hit && LOAD_LAT > 1) begin
            state <= S_STALL;
            cnt   <= LAT_M1;
          end
        end
        S_STALL: begin
          if (cnt == 3'd1) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign hif.FORWARD = RST ? '0 : fwd;
  assign hif.STALL   = stall;
  assign hif.BUBBLE  = bubble;
  assign hif.BUSY    = (state == S_STALL) && !RST;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic [31:0] fwd_n;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_n = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (fwd[2*i +: 2] != 2'b00)
        fwd_n = fwd_n + 32'd1;
    end
    fwd_sum = {1'b0, fwd_cnt} + {1'b0, fwd_n};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  assign hif.STALL_CNT = stall_cnt;
  assign hif.FWD_CNT   = fwd_cnt;
`else
  assign hif.STALL_CNT = '0;
  assign hif.FWD_CNT   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit with LOAD_LAT=3, NUM_SRC=2, AW=5.
module tb_hazard_forward_unit;

`ifdef HAZARD_STATS_EN
  localparam logic [31:0] EXP_STALL_CNT = 32'd3;
  localparam logic [31:0] EXP_FWD_CNT   = 32'd2;
`else
  localparam logic [31:0] EXP_STALL_CNT = 32'd0;
  localparam logic [31:0] EXP_FWD_CNT   = 32'd0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   bubbles;

  hazard_forward_unit_if #(.AW(5), .NUM_SRC(2)) hif ();

  hazard_forward_unit #(
    .AW(5),
    .NUM_SRC(2),
    .LOAD_LAT(3)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .hif(hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hif.ARS_EX          = '0;
    hif.ARS_ID          = '0;
    hif.SRC_VALID_ID    = '0;
    hif.ARD_ID_EX       = '0;
    hif.MEMREAD_ID_EX   = 1'b0;
    hif.ARD_EX_MEM      = '0;
    hif.REGWRITE_EX_MEM = 1'b0;
    hif.ARD_MEM_WB      = '0;
    hif.REGWRITE_MEM_WB = 1'b0;
    hif.FLUSH           = 1'b0;
    hif.MEM_WAIT        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load to x4 in ID/EX; ID operand 0 reads x4.
  task automatic load_use();
    hif.MEMREAD_ID_EX = 1'b1;
    hif.ARD_ID_EX     = 5'd4;
    hif.ARS_ID        = {5'd0, 5'd4};
    hif.SRC_VALID_ID  = 2'b01;
  endtask

  task automatic dual_fwd();
    hif.ARS_EX          = {5'd5, 5'd5};
    hif.REGWRITE_EX_MEM = 1'b1;
    hif.ARD_EX_MEM      = 5'd5;
    hif.REGWRITE_MEM_WB = 1'b1;
    hif.ARD_MEM_WB      = 5'd5;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic y);
    check({tag, "_stall"},  32'(hif.STALL),  32'(s));
    check({tag, "_bubble"}, 32'(hif.BUBBLE), 32'(b));
    check({tag, "_busy"},   32'(hif.BUSY),   32'(y));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    dual_fwd();
    load_use();
    #3;
    check("rst_fwd", 32'(hif.FORWARD), 32'h0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_stall_cnt", hif.STALL_CNT, 32'h0);
    check("rst_fwd_cnt", hif.FWD_CNT, 32'h0);
    idle();
    rst = 1'b0;
    tick();

    // LOAD_LAT=3 load-use stall, then one dual forward cycle
    load_use();
    #1;
    chk_ctl("lu_c1", 1'b1, 1'b1, 1'b0);
    tick();
    hif.MEMREAD_ID_EX = 1'b0;
    #1;
    chk_ctl("lu_c2", 1'b1, 1'b1, 1'b1);
    tick();
    chk_ctl("lu_c3", 1'b1, 1'b1, 1'b1);
    tick();
    chk_ctl("lu_done", 1'b0, 1'b0, 1'b0);
    dual_fwd();
    #1;
    check("fwd_dual", 32'(hif.FORWARD), 32'b1010);
    tick();
    idle();
    #1;
    check("stats_stall_cnt", hif.STALL_CNT, EXP_STALL_CNT);
    check("stats_fwd_cnt", hif.FWD_CNT, EXP_FWD_CNT);

    // Reset asserted mid-stall
    load_use();
    tick();
    hif.MEMREAD_ID_EX = 1'b0;
    dual_fwd();
    #1;
    check("mid_busy_pre", 32'(hif.BUSY), 32'h1);
    rst = 1'b1;
    #1;
    chk_ctl("mid_rst", 1'b0, 1'b0, 1'b0);
    check("mid_rst_fwd", 32'(hif.FORWARD), 32'h0);
    check("mid_rst_stall_cnt", hif.STALL_CNT, 32'h0);
    check("mid_rst_fwd_cnt", hif.FWD_CNT, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);

    // Forwarding patterns
    dual_fwd();
    hif.MEM_WAIT = 1'b1;
    hif.FLUSH    = 1'b1;
    #1;
    check("fwd_dual_frozen", 32'(hif.FORWARD), 32'b1010);
    hif.MEM_WAIT = 1'b0;
    hif.FLUSH    = 1'b0;
    hif.REGWRITE_EX_MEM = 1'b0;
    #1;
    check("fwd_memwb_only", 32'(hif.FORWARD), 32'b0101);
    hif.REGWRITE_MEM_WB = 1'b0;
    #1;
    check("fwd_no_regwrite", 32'(hif.FORWARD), 32'b0000);
    hif.ARS_EX          = {5'd3, 5'd7};
    hif.REGWRITE_EX_MEM = 1'b1;
    hif.ARD_EX_MEM      = 5'd3;
    hif.REGWRITE_MEM_WB = 1'b1;
    hif.ARD_MEM_WB      = 5'd7;
    #1;
    check("fwd_concurrent", 32'(hif.FORWARD), 32'b1001);
    hif.ARS_EX     = {5'd0, 5'd0};
    hif.ARD_EX_MEM = 5'd0;
    hif.ARD_MEM_WB = 5'd0;
    #1;
    check("fwd_x0", 32'(hif.FORWARD), 32'b0000);
    idle();
    tick();

    // No stall when operand does not read, or load targets x0
    load_use();
    hif.SRC_VALID_ID = 2'b10;
    #1;
    chk_ctl("lu_invalid", 1'b0, 1'b0, 1'b0);
    load_use();
    hif.ARD_ID_EX = 5'd0;
    hif.ARS_ID    = {5'd0, 5'd0};
    #1;
    chk_ctl("lu_x0", 1'b0, 1'b0, 1'b0);
    load_use();
    hif.ARS_ID       = {5'd4, 5'd9};
    hif.SRC_VALID_ID = 2'b10;
    #1;
    chk_ctl("lu_op1", 1'b1, 1'b1, 1'b0);
    hif.FLUSH = 1'b1;
    #1;
    chk_ctl("flush_idle", 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk_ctl("flush_idle_next", 1'b0, 1'b0, 1'b0);

    // FLUSH in the 2nd stall cycle
    load_use();
    tick();
    hif.MEMREAD_ID_EX = 1'b0;
    hif.FLUSH         = 1'b1;
    #1;
    chk_ctl("flush_c2", 1'b0, 1'b0, 1'b1);
    hif.MEM_WAIT = 1'b1;
    #1;
    chk_ctl("flush_memwait", 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    chk_ctl("flush_after", 1'b0, 1'b0, 1'b0);

    // MEM_WAIT for 4 cycles during the 2nd stall cycle
    bubbles = 0;
    load_use();
    #1;
    if (hif.BUBBLE) bubbles++;
    tick();
    hif.MEMREAD_ID_EX = 1'b0;
    hif.MEM_WAIT      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl("mw_hold", 1'b1, 1'b0, 1'b1);
      if (hif.BUBBLE) bubbles++;
      tick();
    end
    hif.MEM_WAIT = 1'b0;
    #1;
    chk_ctl("mw_resume", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (hif.BUBBLE) bubbles++;
      tick();
    end
    check("mw_bubbles", 32'(bubbles), 32'd3);
    chk_ctl("mw_done", 1'b0, 1'b0, 1'b0);

    // MEM_WAIT in IDLE defers the hit
    load_use();
    hif.MEM_WAIT = 1'b1;
    #1;
    chk_ctl("mw_idle", 1'b1, 1'b0, 1'b0);
    tick();
    chk_ctl("mw_idle_held", 1'b1, 1'b0, 1'b0);
    hif.MEM_WAIT = 1'b0;
    #1;
    chk_ctl("mw_idle_drop", 1'b1, 1'b1, 1'b0);
    tick();
    hif.MEMREAD_ID_EX = 1'b0;
    #1;
    chk_ctl("mw_idle_stall", 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk_ctl("mw_idle_done", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
